seg_scan_capture: RTL and testbench



---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_scan_capture_if.sv | 31 +++
 rtl/seg_stab_filter.sv | 81 ++++++++
 rtl/seg_scan_capture.sv | 114 +++++++++++
 tb/tb_seg_scan_capture.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and sizes for the scanned display bus capture block.
package seg_pkg;

  localparam int unsigned NDIG  = 8;
  localparam int unsigned AN_W  = $clog2(NDIG);
  localparam int unsigned DIG_W = 4;

  typedef logic [DIG_W-1:0] digit_t;

  // Packed so that nibble k of the flattened frame is digit position k.
  typedef digit_t [NDIG-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    STALL
  } state_t;

  // One-hot mask for a digit position.
  function automatic logic [NDIG-1:0] an_onehot(input logic [AN_W-1:0] an);
    logic [NDIG-1:0] one;
    one = {{(NDIG-1){1'b0}}, 1'b1};
    return one << an;
  endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Scanned display bus plus the reconstructed-frame outputs of the capture block.
// master: the display driver / bench side; slave: the capture block.
interface seg_scan_capture_if;
  import seg_pkg::*;

  logic [AN_W-1:0]         seg_an;
  digit_t                  seg_data;
  logic [NDIG*DIG_W-1:0]   value;
  logic                    frame_valid;
  logic [NDIG-1:0]         digit_seen;
  logic                    stalled;

  modport master (
    output seg_an,
    output seg_data,
    input  value,
    input  frame_valid,
    input  digit_seen,
    input  stalled
  );

  modport slave (
    input  seg_an,
    input  seg_data,
    output value,
    output frame_valid,
    output digit_seen,
    output stalled
  );

endinterface

// File: rtl/seg_stab_filter.sv
// Input stage and stability filter for the scanned display bus.
// Optional macro SEG_CAP_SYNC_EN adds a 2-flop synchronizer ahead of the input
// register (commit latency HOLD+2 instead of HOLD).
// commit is a single-cycle strobe, valid for the edge on which the registered
// sample has been held for HOLD consecutive edges; an/data are that sample.
module seg_stab_filter
  import seg_pkg::*;
#(
  parameter int unsigned HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AN_W-1:0] seg_an,
  input  digit_t          seg_data,
  output logic            commit,
  output logic [AN_W-1:0] an,
  output digit_t          data
);

  localparam int unsigned SMP_W = AN_W + DIG_W;
  localparam int unsigned CNT_W = $clog2(HOLD + 1);

  logic [SMP_W-1:0] raw;
  logic [SMP_W-1:0] in_s;
  logic [SMP_W-1:0] sample_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             same;

  assign raw = {seg_an, seg_data};

`ifdef SEG_CAP_SYNC_EN
  logic [SMP_W-1:0] sync1_q;
  logic [SMP_W-1:0] sync2_q;

  // Two-flop synchronizer for pins from an unrelated clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = raw;
`endif

  // Incoming sample matches what the input register already holds.
  assign same = (in_s == sample_q);

  // Dwell counter: restarts at 1 on a change, saturates at HOLD.
  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_W'(HOLD)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires only on the step into HOLD, so once per dwell.
  assign commit = same && (cnt_q == CNT_W'(HOLD - 1));

  // Input register and dwell counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      cnt_q    <= '0;
    end else begin
      sample_q <= in_s;
      cnt_q    <= cnt_d;
    end
  end

  assign {an, data} = sample_q;

endmodule

// File: rtl/seg_scan_capture.sv
// Receiver for the time-multiplexed display bus: filters glitches, rebuilds the
// 8-digit value, flags complete frames and detects a stalled scan.
// Optional macro SEG_CAP_SYNC_EN (handled in seg_stab_filter) adds an input
// synchronizer.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned HOLD    = 4,
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic               clk,
  input logic               rst,
  seg_scan_capture_if.slave bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic                  commit;
  logic [AN_W-1:0]       c_an;
  digit_t                c_data;

  state_t                state_q;
  frame_t                dig_buf_q;
  frame_t                dig_buf_upd;
  logic [NDIG-1:0]       seen_q;
  logic [NDIG-1:0]       seen_upd;
  logic [TMO_W-1:0]      tmo_q;
  logic [NDIG*DIG_W-1:0] value_q;
  logic                  fv_q;
  logic                  stalled_q;

  seg_stab_filter #(
    .HOLD (HOLD)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .seg_an   (bus.seg_an),
    .seg_data (bus.seg_data),
    .commit   (commit),
    .an       (c_an),
    .data     (c_data)
  );

  // Buffer and seen mask as they would look with the current commit applied.
  always_comb begin
    dig_buf_upd       = dig_buf_q;
    dig_buf_upd[c_an] = c_data;
    seen_upd          = seen_q | an_onehot(c_an);
  end

  // Capture FSM with registered outputs; a commit always beats a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dig_buf_q <= '0;
      seen_q    <= '0;
      tmo_q     <= '0;
      value_q   <= '0;
      fv_q      <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      if (commit) begin
        dig_buf_q <= dig_buf_upd;
      end
      case (state_q)
        IDLE: begin
          if (commit) begin
            state_q <= SCAN;
            seen_q  <= an_onehot(c_an);
            tmo_q   <= '0;
          end
        end
        SCAN: begin
          if (commit) begin
            tmo_q <= '0;
            if (&seen_upd) begin
              value_q <= dig_buf_upd;
              fv_q    <= 1'b1;
              seen_q  <= '0;
            end else begin
              seen_q <= seen_upd;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_q   <= STALL;
            stalled_q <= 1'b1;
            seen_q    <= '0;
            tmo_q     <= TMO_W'(TIMEOUT);
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        STALL: begin
          // First commit after a stall starts a fresh frame.
          if (commit) begin
            state_q   <= SCAN;
            stalled_q <= 1'b0;
            seen_q    <= an_onehot(c_an);
            tmo_q     <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.value       = value_q;
  assign bus.frame_valid = fv_q;
  assign bus.digit_seen  = seen_q;
  assign bus.stalled     = stalled_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with a frame scoreboard.
module tb_seg_scan_capture;
  import seg_pkg::*;

  localparam int unsigned HOLD    = 4;
  localparam int unsigned TIMEOUT = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int f0     = 0;

  logic [31:0] exp_q[$];

  seg_scan_capture_if bus ();

  seg_scan_capture #(
    .HOLD    (HOLD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold one bus value for n cycles; called and returns just after a rising edge.
  task automatic dwell(input logic [2:0] an, input logic [3:0] d, input int n);
    bus.seg_an   = an;
    bus.seg_data = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Poll until a position is accepted; returns just after the commit edge.
  task automatic wait_seen(input int idx, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = bus.digit_seen[idx];
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // Scoreboard consumer: every frame pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && bus.frame_valid === 1'b1) begin
      frames++;
      check("frame_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("frame_value", bus.value, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bus.seg_an   = '0;
    bus.seg_data = '0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", bus.value, 32'h0);
    check("rst_fv", 32'(bus.frame_valid), 32'd0);
    check("rst_seen", 32'(bus.digit_seen), 32'h0);
    check("rst_stalled", 32'(bus.stalled), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean scan.
    exp_q.push_back(32'h76543210);
    f0 = frames;
    for (int k = 0; k < 4; k++) dwell(3'(k), 4'(k), 10);
    check("clean_mid_seen", 32'(bus.digit_seen), 32'h0f);
    for (int k = 4; k < 8; k++) dwell(3'(k), 4'(k), 10);
    check("clean_frames", frames - f0, 32'd1);
    check("clean_value", bus.value, 32'h76543210);
    check("clean_seen", 32'(bus.digit_seen), 32'h0);

    // Short blip at position 3 must not be accepted.
    exp_q.push_back(32'hfedcba98);
    f0 = frames;
    dwell(3'd0, 4'h8, 10);
    dwell(3'd1, 4'h9, 10);
    dwell(3'd3, 4'hf, 2);
    dwell(3'd2, 4'ha, 10);
    check("glitch_seen", 32'(bus.digit_seen), 32'h07);
    check("glitch_value", bus.value, 32'h76543210);
    for (int k = 3; k < 8; k++) dwell(3'(k), 4'(k + 8), 10);
    check("glitch_frames", frames - f0, 32'd1);
    check("glitch_final", bus.value, 32'hfedcba98);

    // Position 2 shown twice within a frame.
    exp_q.push_back(32'h76543510);
    f0 = frames;
    dwell(3'd2, 4'ha, 10);
    dwell(3'd0, 4'h0, 10);
    dwell(3'd1, 4'h1, 10);
    dwell(3'd2, 4'h5, 10);
    check("ovw_seen", 32'(bus.digit_seen), 32'h07);
    for (int k = 3; k < 8; k++) dwell(3'(k), 4'(k), 10);
    check("ovw_frames", frames - f0, 32'd1);
    check("ovw_value", bus.value, 32'h76543510);

    // Stall after four digits.
    f0 = frames;
    for (int k = 0; k < 3; k++) dwell(3'(k), 4'hc, 10);
    bus.seg_an   = 3'd3;
    bus.seg_data = 4'hc;
    wait_seen(3, "stall_commit");
    repeat (49) @(posedge clk);
    #1;
    check("stall_early", 32'(bus.stalled), 32'd0);
    @(posedge clk);
    #1;
    check("stall_set", 32'(bus.stalled), 32'd1);
    check("stall_seen", 32'(bus.digit_seen), 32'h0);
    check("stall_value", bus.value, 32'h76543510);
    repeat (20) @(posedge clk);
    #1;
    check("stall_hold", 32'(bus.stalled), 32'd1);
    check("stall_frames", frames - f0, 32'd0);

    // Resume: first commit clears stall and starts a fresh frame.
    exp_q.push_back(32'h01234567);
    f0 = frames;
    dwell(3'd0, 4'h7, 10);
    check("resume_stalled", 32'(bus.stalled), 32'd0);
    check("resume_seen", 32'(bus.digit_seen), 32'h01);
    for (int k = 1; k < 8; k++) dwell(3'(k), 4'(7 - k), 10);
    check("resume_frames", frames - f0, 32'd1);
    check("resume_value", bus.value, 32'h01234567);

    // Commit landing exactly on the timeout edge.
    bus.seg_an   = 3'd0;
    bus.seg_data = 4'h1;
    wait_seen(0, "coll_first");
    repeat (46) @(posedge clk);
    #1;
    bus.seg_an   = 3'd1;
    bus.seg_data = 4'h1;
    repeat (4) @(posedge clk);
    #1;
    check("coll_stalled", 32'(bus.stalled), 32'd0);
    check("coll_seen", 32'(bus.digit_seen), 32'h03);
    repeat (10) @(posedge clk);
    #1;
    check("coll_later", 32'(bus.stalled), 32'd0);

    // Asynchronous reset in the middle of a frame.
    dwell(3'd2, 4'h2, 10);
    #3;
    rst = 1'b1;
    #1;
    check("arst_value", bus.value, 32'h0);
    check("arst_fv", 32'(bus.frame_valid), 32'd0);
    check("arst_seen", 32'(bus.digit_seen), 32'h0);
    check("arst_stalled", 32'(bus.stalled), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    exp_q.push_back(32'h7654fedc);
    f0 = frames;
    for (int k = 4; k < 8; k++) dwell(3'(k), 4'(k), 10);
    check("post_rst_partial", frames - f0, 32'd0);
    check("post_rst_seen", 32'(bus.digit_seen), 32'hf0);
    for (int k = 0; k < 4; k++) dwell(3'(k), 4'(k + 12), 10);
    check("post_rst_frames", frames - f0, 32'd1);
    check("post_rst_value", bus.value, 32'h7654fedc);

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("total_frames", frames, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
